hack_dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between the Hack CPU data port and the screen scan-out reader.
- The CPU has priority. A starvation counter forces one video slot after STARVE_MAX consecutive conflict cycles; during that slot the CPU is stalled through a clock-enable style stall line.
- Sits between the cpu block (addressM/outM/writeM/inM) and the RAM. Read data returns one cycle after grant.

---
 rtl/hack_dmem_arbiter_if.sv | 35 +++
 rtl/hack_dmem_arbiter.sv | 73 +++++++
 tb/tb_hack_dmem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hack_dmem_arbiter_if.sv
// Bus bundle between the Hack CPU data port, the screen reader and the data RAM.
// The arbiter takes the slave view; the clients/RAM side takes the master view.
interface hack_dmem_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/hack_dmem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, video gets a forced slot after
// STARVE_MAX consecutive lost conflicts. Read data returns one cycle after grant.
module hack_dmem_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset,
  hack_dmem_arbiter_if.slave bus
);
  typedef enum logic {PRI_CPU = 1'b0, FORCE_VID = 1'b1} state_t;

  state_t        state, nxt_state;
  logic [3:0]    starve_cnt, nxt_cnt, cnt_inc;
  logic [1:0]    rd_owner;
  logic          cpu_gnt, vid_gnt_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PRI_CPU;
      starve_cnt <= 4'd0;
      rd_owner   <= 2'b00;
    end else begin
      state      <= nxt_state;
      starve_cnt <= nxt_cnt;
      rd_owner   <= {vid_gnt_c, cpu_gnt & ~bus.cpu_we};
    end
  end

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    cpu_gnt   = 1'b0;
    vid_gnt_c = 1'b0;
    if (!reset) begin
      if (state == FORCE_VID && bus.vid_req) vid_gnt_c = 1'b1;
      else if (bus.cpu_req)                  cpu_gnt   = 1'b1;
      else if (bus.vid_req)                  vid_gnt_c = 1'b1;
    end
  end

  always_comb begin
    cnt_inc   = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
    nxt_state = PRI_CPU;
    nxt_cnt   = 4'd0;
    if (bus.cpu_req && bus.vid_req && cpu_gnt) begin
      if (cnt_inc == 4'(STARVE_MAX)) nxt_state = FORCE_VID;
      else                           nxt_cnt   = cnt_inc;
    end
  end

  always_comb begin
    addr_c  = '0;
    wdata_c = '0;
    if (cpu_gnt) begin
      addr_c  = bus.cpu_addr;
      wdata_c = bus.cpu_wdata;
    end else if (vid_gnt_c) begin
      addr_c  = bus.vid_addr;
    end
    bus.mem_addr   = addr_c;
    bus.mem_wdata  = wdata_c;
    bus.mem_we     = cpu_gnt & bus.cpu_we;
    bus.cpu_stall  = bus.cpu_req & ~cpu_gnt & ~reset;
    bus.vid_gnt    = vid_gnt_c;
    bus.cpu_rvalid = rd_owner[0];
    bus.vid_rvalid = rd_owner[1];
    bus.cpu_rdata  = bus.mem_rdata;
    bus.vid_rdata  = bus.mem_rdata;
  end
endmodule

// File: tb/tb_hack_dmem_arbiter.sv
// Directed bench for hack_dmem_arbiter with a small synchronous RAM model.
module tb_hack_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  hack_dmem_arbiter_if #(.AW(15), .DW(16)) bus ();

  hack_dmem_arbiter #(.AW(15), .DW(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:32767];
  always @(posedge clk) begin
    if (reset) ram[15'h4000] <= 16'hBEEF;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let comb outputs settle.
  task automatic drive(input logic cr, input logic cw, input logic [14:0] ca,
                       input logic [15:0] cd, input logic vr, input logic [14:0] va);
    @(negedge clk);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.vid_req = vr; bus.vid_addr = va;
    #1;
  endtask

  initial begin
    logic prev_cpu, prev_vid, exp_vid;
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0010;
    bus.cpu_wdata = 16'h5555; bus.vid_req = 1'b1; bus.vid_addr = 15'h4000;

    // Reset held with both requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_stall",  bus.cpu_stall, 0);
      chk("rst_vgnt",   bus.vid_gnt, 0);
      chk("rst_we",     bus.mem_we, 0);
      chk("rst_addr",   bus.mem_addr, 0);
      chk("rst_wdata",  bus.mem_wdata, 0);
      chk("rst_crv",    bus.cpu_rvalid, 0);
      chk("rst_vrv",    bus.vid_rvalid, 0);
    end

    @(negedge clk);
    reset = 1'b0; bus.cpu_we = 1'b0;
    #1;
    chk("post_rst_stall", bus.cpu_stall, 0);
    chk("post_rst_vgnt",  bus.vid_gnt, 0);
    chk("post_rst_addr",  bus.mem_addr, 15'h0010);

    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    chk("post_rst_crv",   bus.cpu_rvalid, 1);
    chk("idle_addr",      bus.mem_addr, 0);
    chk("idle_we",        bus.mem_we, 0);

    // CPU write then read back
    drive(1, 1, 15'h0010, 16'h1234, 0, 15'h0);
    chk("wr_we",    bus.mem_we, 1);
    chk("wr_addr",  bus.mem_addr, 15'h0010);
    chk("wr_wdata", bus.mem_wdata, 16'h1234);
    chk("wr_stall", bus.cpu_stall, 0);
    drive(1, 0, 15'h0010, 16'h0, 0, 15'h0);
    chk("rd_we",    bus.mem_we, 0);
    chk("rd_stall", bus.cpu_stall, 0);
    chk("wr_no_rv", bus.cpu_rvalid, 0);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    chk("rd_rv",    bus.cpu_rvalid, 1);
    chk("rd_data",  bus.cpu_rdata, 16'h1234);
    chk("rd_vrv",   bus.vid_rvalid, 0);

    // Video-only read
    drive(0, 0, 15'h0, 16'h0, 1, 15'h4000);
    chk("vid_gnt",   bus.vid_gnt, 1);
    chk("vid_addr",  bus.mem_addr, 15'h4000);
    chk("vid_we",    bus.mem_we, 0);
    chk("vid_stall", bus.cpu_stall, 0);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    chk("vid_rv",    bus.vid_rvalid, 1);
    chk("vid_data",  bus.vid_rdata, 16'hBEEF);
    chk("vid_crv",   bus.cpu_rvalid, 0);

    // Continuous conflict: video forced every 5th cycle
    prev_cpu = 1'b0; prev_vid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 15'h0010, 16'h0, 1, 15'h4000);
      exp_vid = (i % 5 == 4);
      chk($sformatf("stv_vgnt%0d", i),  bus.vid_gnt, exp_vid);
      chk($sformatf("stv_stall%0d", i), bus.cpu_stall, exp_vid);
      chk($sformatf("stv_addr%0d", i),  bus.mem_addr, exp_vid ? 15'h4000 : 15'h0010);
      chk($sformatf("stv_crv%0d", i),   bus.cpu_rvalid, prev_cpu);
      chk($sformatf("stv_vrv%0d", i),   bus.vid_rvalid, prev_vid);
      prev_cpu = ~exp_vid; prev_vid = exp_vid;
    end

    // CPU write vs video read in PRI_CPU: write wins (conflict #1)
    drive(1, 1, 15'h0020, 16'hA5A5, 1, 15'h4000);
    chk("wvv_we",    bus.mem_we, 1);
    chk("wvv_vgnt",  bus.vid_gnt, 0);
    chk("wvv_addr",  bus.mem_addr, 15'h0020);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 15'h0010, 16'h0, 1, 15'h4000);
      chk($sformatf("pre_force_vgnt%0d", i), bus.vid_gnt, 0);
    end
    // FORCE_VID: a CPU write loses to the video read
    drive(1, 1, 15'h0020, 16'h0F0F, 1, 15'h4000);
    chk("fv_wr_vgnt",  bus.vid_gnt, 1);
    chk("fv_wr_we",    bus.mem_we, 0);
    chk("fv_wr_stall", bus.cpu_stall, 1);

    // Reach FORCE_VID again, then abandon the slot
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 15'h0010, 16'h0, 1, 15'h4000);
      chk($sformatf("pre_ab_vgnt%0d", i), bus.vid_gnt, 0);
    end
    drive(1, 0, 15'h0030, 16'h0, 0, 15'h4000);
    chk("ab_vgnt",  bus.vid_gnt, 0);
    chk("ab_stall", bus.cpu_stall, 0);
    chk("ab_addr",  bus.mem_addr, 15'h0030);
    // Counter cleared and back in PRI_CPU: four more CPU wins, then video
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 15'h0010, 16'h0, 1, 15'h4000);
      chk($sformatf("ab_after_vgnt%0d", i), bus.vid_gnt, (i == 4));
    end

    // Reset mid-read drops the pending video rvalid
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    drive(0, 0, 15'h0, 16'h0, 1, 15'h4000);
    chk("mid_vgnt", bus.vid_gnt, 1);
    #2 reset = 1'b1;
    #1 chk("mid_rst_vgnt", bus.vid_gnt, 0);
    @(negedge clk); #1;
    chk("mid_rst_vrv", bus.vid_rvalid, 0);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    reset = 1'b0;
    #1 chk("mid_rel_vrv", bus.vid_rvalid, 0);
    drive(0, 0, 15'h0, 16'h0, 0, 15'h0);
    chk("mid_rel_vrv2", bus.vid_rvalid, 0);
    chk("mid_rel_crv2", bus.cpu_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
